// File: rtl/transpose_chunk_sequencer.sv
// Tile-by-tile transpose/copy sequencer issuing one chunk-move request per tile.
// Optional PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module transpose_chunk_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int ARR_SIZE   = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNK_SIZE = 4,
    localparam int G         = ARR_SIZE / CHUNK_SIZE,
    localparam int TL_W      = $clog2(G * G) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ctrl,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_src,
    output logic [ADDR_WIDTH-1:0] req_dst,
    input  logic                  chunk_done,
    output logic                  busy,
    output logic                  done,
    output logic [TL_W-1:0]       tiles_left
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int EB         = DATA_WIDTH / 8;
    localparam int ROW_B      = ARR_SIZE * EB;
    localparam int TILE_ROW_B = CHUNK_SIZE * ROW_B;
    localparam int TILE_COL_B = CHUNK_SIZE * EB;
    localparam int RC_W       = (G > 1) ? $clog2(G) : 1;

    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(G - 1);
    localparam logic [RC_W-1:0] RC_ONE   = RC_W'(1);
    localparam logic [TL_W-1:0] TL_ALL   = TL_W'(G * G);
    localparam logic [TL_W-1:0] TL_ONE   = TL_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic                  tile_fin;
    logic                  last_tile;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [RC_W-1:0]       r_q;
    logic [RC_W-1:0]       c_q;
    logic [RC_W-1:0]       r_nxt;
    logic [RC_W-1:0]       c_nxt;
    logic [ADDR_WIDTH-1:0] src_nxt;
    logic [ADDR_WIDTH-1:0] dst_nxt;

    // Byte offset of tile (a,b) where a indexes tile rows and b tile columns.
    function automatic logic [ADDR_WIDTH-1:0] offs(
        input logic [RC_W-1:0] a,
        input logic [RC_W-1:0] b
    );
        return ADDR_WIDTH'(a) * ADDR_WIDTH'(TILE_ROW_B)
             + ADDR_WIDTH'(b) * ADDR_WIDTH'(TILE_COL_B);
    endfunction

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        tile_fin  = 1'b0;
        req_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last_tile = (tiles_left == TL_ONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_valid = 1'b1;
                busy      = 1'b1;
                if (req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (chunk_done) begin
                    tile_fin = 1'b1;
                    state_d  = last_tile ? FIN : ISSUE;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row-major advance to the next tile and its addresses.
    always_comb begin
        c_nxt = (c_q == RC_LAST) ? '0 : c_q + RC_ONE;
        r_nxt = (c_q == RC_LAST) ? r_q + RC_ONE : r_q;
        src_nxt = src_q + offs(r_nxt, c_nxt);
        if (mode_q) begin
            dst_nxt = dst_q + offs(c_nxt, r_nxt);
        end else begin
            dst_nxt = dst_q + offs(r_nxt, c_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            req_src    <= '0;
            req_dst    <= '0;
            tiles_left <= '0;
        end else if (accept) begin
            mode_q     <= ctrl;
            src_q      <= src_base;
            dst_q      <= dst_base;
            r_q        <= '0;
            c_q        <= '0;
            req_src    <= src_base;
            req_dst    <= dst_base;
            tiles_left <= TL_ALL;
        end else if (tile_fin) begin
            tiles_left <= tiles_left - TL_ONE;
            if (!last_tile) begin
                r_q     <= r_nxt;
                c_q     <= c_nxt;
                req_src <= src_nxt;
                req_dst <= dst_nxt;
            end
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_transpose_chunk_sequencer.sv
// Directed bench for transpose_chunk_sequencer (default parameters, G=2).
// Build with PERF_CNT_EN defined to also cover perf_cycles.
module tb_transpose_chunk_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ctrl;
    logic [63:0] src_base;
    logic [63:0] dst_base;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_src;
    logic [63:0] req_dst;
    logic        chunk_done;
    logic        busy;
    logic        done;
    logic [2:0]  tiles_left;
`ifdef PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    int vectors;
    int miscompares;
    int hs;
    int hs_mark;

    transpose_chunk_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ctrl       (ctrl),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .chunk_done (chunk_done),
        .busy       (busy),
        .done       (done),
        .tiles_left (tiles_left)
`ifdef PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial hs = 0;
    always @(posedge clk) begin
        if (req_valid && req_ready) hs = hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge in IDLE; leaves at the negedge of the first ISSUE cycle.
    task automatic cmd(input logic m, input logic [63:0] s,
                       input logic [63:0] d);
        ctrl     = m;
        src_base = s;
        dst_base = d;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_base = 64'h5A5A_5A5A_5A5A_5A5A;
        dst_base = 64'hA5A5_A5A5_A5A5_A5A5;
        ctrl     = ~m;
        chk("cmd_busy", busy, 1);
    endtask

    // Entered at the negedge of an ISSUE cycle; mover answers 2 cycles after accept.
    task automatic tile(input logic [63:0] s, input logic [63:0] d,
                        input int left, input int stall, input bit spur);
        req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("bp_valid", req_valid, 1);
            chk("bp_src", req_src, s);
            chk("bp_dst", req_dst, d);
            chk("bp_left", tiles_left, 64'(left));
            if (spur && i == 0) begin
                start      = 1'b1;
                chunk_done = 1'b1;
                src_base   = 64'hDEAD_0000_0000_0000;
                dst_base   = 64'hBEEF_0000_0000_0000;
            end
            @(negedge clk);
            start      = 1'b0;
            chunk_done = 1'b0;
        end
        chk("req_valid", req_valid, 1);
        chk("req_src", req_src, s);
        chk("req_dst", req_dst, d);
        chk("req_left", tiles_left, 64'(left));
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("wait_valid", req_valid, 0);
        chk("wait_busy", busy, 1);
        @(negedge clk);
        chunk_done = 1'b1;
        @(negedge clk);
        chunk_done = 1'b0;
    endtask

    // Entered at the negedge of the FIN cycle.
    task automatic fin(input bit poke);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_left", tiles_left, 0);
        chk("fin_valid", req_valid, 0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        ctrl        = 1'b0;
        src_base    = '0;
        dst_base    = '0;
        req_ready   = 1'b0;
        chunk_done  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_src", req_src, 0);
        chk("rst_dst", req_dst, 0);
        chk("rst_left", tiles_left, 0);
`ifdef PERF_CNT_EN
        chk("rst_perf", perf_cycles, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Transpose
        hs_mark = hs;
        cmd(1'b1, 64'h1000, 64'h2000);
        tile(64'h1000, 64'h2000, 4, 0, 1'b0);
        tile(64'h1020, 64'h2100, 3, 0, 1'b0);
        tile(64'h1100, 64'h2020, 2, 0, 1'b0);
        tile(64'h1120, 64'h2120, 1, 0, 1'b0);
`ifdef PERF_CNT_EN
        chk("perf_fin", perf_cycles, 12);
`endif
        fin(1'b0);
        chk("t1_handshakes", 64'(hs - hs_mark), 4);
`ifdef PERF_CNT_EN
        repeat (3) @(negedge clk);
        chk("perf_hold", perf_cycles, 12);
`endif

        // Copy with backpressure on the second tile; start poked during FIN
        hs_mark = hs;
        cmd(1'b0, 64'h1000, 64'h2000);
        tile(64'h1000, 64'h2000, 4, 0, 1'b0);
        tile(64'h1020, 64'h2020, 3, 5, 1'b0);
        tile(64'h1100, 64'h2100, 2, 0, 1'b0);
        tile(64'h1120, 64'h2120, 1, 0, 1'b0);
        fin(1'b1);
        chk("t2_handshakes", 64'(hs - hs_mark), 4);
        @(negedge clk);
        chk("fin_start_ign", busy, 0);

        // Spurious start/chunk_done during ISSUE
        cmd(1'b1, 64'h1000, 64'h2000);
        tile(64'h1000, 64'h2000, 4, 2, 1'b1);
        tile(64'h1020, 64'h2100, 3, 2, 1'b1);
        tile(64'h1100, 64'h2020, 2, 0, 1'b0);
        tile(64'h1120, 64'h2120, 1, 0, 1'b0);
        fin(1'b0);

        // Reset after second tile accepted
        cmd(1'b1, 64'h1000, 64'h2000);
        tile(64'h1000, 64'h2000, 4, 0, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", req_valid, 0);
        chk("mid_rst_left", tiles_left, 0);
        chk("mid_rst_src", req_src, 0);
        chunk_done = 1'b1;
        @(negedge clk);
        chunk_done = 1'b0;
        chk("idle_cd_left", tiles_left, 0);
        chk("idle_cd_busy", busy, 0);

        // Address wrap
        cmd(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'h0);
        tile(64'hFFFF_FFFF_FFFF_FF00, 64'h000, 4, 0, 1'b0);
        tile(64'hFFFF_FFFF_FFFF_FF20, 64'h100, 3, 0, 1'b0);
        tile(64'h0000_0000_0000_0000, 64'h020, 2, 0, 1'b0);
        tile(64'h0000_0000_0000_0020, 64'h120, 1, 0, 1'b0);
        fin(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
